// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - bit-serial word receiver (start, WIDTH data bits LSB first, stop) with valid/ready output
module serial_word_rx #(
    parameter int   WIDTH      = 48,
    parameter int   BIT_PERIOD = 1252,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(BIT_PERIOD);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_PERIOD / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic          ACTIVE    = ~IDLE_LEVEL;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    logic [2:0]       prime;
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_idx;
    logic [WIDTH-1:0] shreg;
    logic             start_edge;
    logic             sample;

    // prime[2] marks that rx_prev holds a real line sample rather than the reset preload,
    // so a line held active through reset cannot fake an idle->active edge.
    assign start_edge = (state == S_IDLE) && prime[2] &&
                        (rx_prev == IDLE_LEVEL) && (rx_s == ACTIVE);

    always_comb begin
        sample = 1'b0;
        case (state)
            S_START:        sample = (cnt == HALF_LAST);
            S_DATA, S_STOP: sample = (cnt == FULL_LAST);
            default:        sample = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= IDLE_LEVEL;
            rx_s    <= IDLE_LEVEL;
            rx_prev <= IDLE_LEVEL;
            prime   <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            prime   <= {prime[1:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (state != S_IDLE) begin
                cnt <= sample ? '0 : cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (sample) begin
                        if (rx_s == ACTIVE) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        shreg   <= {rx_s, shreg[WIDTH-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        state <= S_IDLE;
                        if (rx_s == IDLE_LEVEL) begin
                            // Output register is free if empty or being drained this same edge.
                            if (!valid || ready) begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// tb/tb_serial_word_rx.sv - self-checking bench for serial_word_rx with a frame-level reference model
module tb_serial_word_rx;

    localparam int   W    = 48;
    localparam int   BP   = 16;
    localparam logic IDLE = 1'b0;
    localparam logic ACT  = 1'b1;
    // cycles from driving the start bit to valid: 2 sync + half bit + (W+1) bits + output register
    localparam int   LAT  = 2 + BP / 2 + (W + 1) * BP + 1;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         rx    = IDLE;
    logic         ready = 1'b1;
    logic [W-1:0] data;
    logic         valid;
    logic         frame_err;
    logic         overrun;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [W-1:0] got_d[$];
    int           got_c[$];
    int           ferr_n = 0;
    int           ferr_c = -1;
    int           ovr_n  = 0;
    int           ovr_c  = -1;

    logic [W-1:0] exp_d[$];
    int           exp_c[$];

    serial_word_rx #(.WIDTH(W), .BIT_PERIOD(BP), .IDLE_LEVEL(IDLE)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && ready) begin
            got_d.push_back(data);
            got_c.push_back(cyc);
        end
        if (frame_err) begin
            ferr_n++;
            ferr_c = cyc;
        end
        if (overrun) begin
            ovr_n++;
            ovr_c = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop_lvl, input int gap_bits, output int t0);
        t0 = cyc;
        rx = ACT;
        tick(BP);
        for (int k = 0; k < W; k++) begin
            rx = d[k];
            tick(BP);
        end
        rx = stop_lvl;
        tick(BP);
        rx = IDLE;
        tick(gap_bits * BP);
    endtask

    task automatic model_word(input logic [W-1:0] d, input int t0);
        exp_d.push_back(d);
        exp_c.push_back(t0 + LAT);
    endtask

    task automatic test_reset();
        int gb;
        int fb;
        gb = got_d.size();
        fb = ferr_n;
        reset = 1'b1;
        rx = ACT;
        tick(3);
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
        n_total++; if (data !== '0) $display("FAIL reset_data got %h want 0", data); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else n_pass++;
        reset = 1'b0;
        tick(4 * BP);
        rx = IDLE;
        tick(LAT + BP);
        n_total++; if (got_d.size() - gb != 0) $display("FAIL held_active_words got %0d want 0", got_d.size() - gb); else n_pass++;
        n_total++; if (ferr_n - fb != 0) $display("FAIL held_active_ferr got %0d want 0", ferr_n - fb); else n_pass++;
    endtask

    task automatic test_nominal();
        int t0, gb, fb, ob;
        gb = got_d.size(); fb = ferr_n; ob = ovr_n;
        exp_d.delete(); exp_c.delete();
        ready = 1'b1;
        send_frame(48'h007FFF3CF7D7, IDLE, 2, t0);
        model_word(48'h007FFF3CF7D7, t0);
        tick(BP);
        n_total++; if (got_d.size() - gb != exp_d.size()) $display("FAIL nominal_count got %0d want %0d", got_d.size() - gb, exp_d.size()); else n_pass++;
        for (int i = 0; i < exp_d.size() && gb + i < got_d.size(); i++) begin
            n_total++; if (got_d[gb+i] !== exp_d[i]) $display("FAIL nominal_data[%0d] got %h want %h", i, got_d[gb+i], exp_d[i]); else n_pass++;
            n_total++; if (got_c[gb+i] != exp_c[i]) $display("FAIL nominal_latency[%0d] got %0d want %0d", i, got_c[gb+i], exp_c[i]); else n_pass++;
        end
        n_total++; if (ferr_n - fb != 0) $display("FAIL nominal_ferr got %0d want 0", ferr_n - fb); else n_pass++;
        n_total++; if (ovr_n - ob != 0) $display("FAIL nominal_overrun got %0d want 0", ovr_n - ob); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t0, t1, gb, fb;
        gb = got_d.size(); fb = ferr_n;
        exp_d.delete(); exp_c.delete();
        ready = 1'b1;
        send_frame(48'h00007F7DF7D7, IDLE, 1, t0);
        model_word(48'h00007F7DF7D7, t0);
        send_frame(48'h007FFF3CF7D7, IDLE, 2, t1);
        model_word(48'h007FFF3CF7D7, t1);
        tick(BP);
        n_total++; if (got_d.size() - gb != exp_d.size()) $display("FAIL b2b_count got %0d want %0d", got_d.size() - gb, exp_d.size()); else n_pass++;
        for (int i = 0; i < exp_d.size() && gb + i < got_d.size(); i++) begin
            n_total++; if (got_d[gb+i] !== exp_d[i]) $display("FAIL b2b_data[%0d] got %h want %h", i, got_d[gb+i], exp_d[i]); else n_pass++;
            n_total++; if (got_c[gb+i] != exp_c[i]) $display("FAIL b2b_latency[%0d] got %0d want %0d", i, got_c[gb+i], exp_c[i]); else n_pass++;
        end
        n_total++; if (ferr_n - fb != 0) $display("FAIL b2b_ferr got %0d want 0", ferr_n - fb); else n_pass++;
    endtask

    task automatic test_glitch();
        int t0, gb, fb;
        logic [W-1:0] d;
        gb = got_d.size(); fb = ferr_n;
        exp_d.delete(); exp_c.delete();
        rx = ACT;
        tick(BP / 2 - 2);
        rx = IDLE;
        tick(2 * BP);
        n_total++; if (got_d.size() - gb != 0) $display("FAIL glitch_words got %0d want 0", got_d.size() - gb); else n_pass++;
        n_total++; if (ferr_n - fb != 0) $display("FAIL glitch_ferr got %0d want 0", ferr_n - fb); else n_pass++;
        d = W'({$urandom(), $urandom()});
        send_frame(d, IDLE, 2, t0);
        model_word(d, t0);
        tick(BP);
        n_total++; if (got_d.size() - gb != exp_d.size()) $display("FAIL glitch_after_count got %0d want %0d", got_d.size() - gb, exp_d.size()); else n_pass++;
        for (int i = 0; i < exp_d.size() && gb + i < got_d.size(); i++) begin
            n_total++; if (got_d[gb+i] !== exp_d[i]) $display("FAIL glitch_after_data got %h want %h", got_d[gb+i], exp_d[i]); else n_pass++;
            n_total++; if (got_c[gb+i] != exp_c[i]) $display("FAIL glitch_after_latency got %0d want %0d", got_c[gb+i], exp_c[i]); else n_pass++;
        end
    endtask

    task automatic test_bad_stop();
        int t0, t1, gb, fb;
        logic [W-1:0] d;
        gb = got_d.size(); fb = ferr_n;
        exp_d.delete(); exp_c.delete();
        send_frame(48'hA5A5A5A5A5A5, ACT, 2, t0);
        n_total++; if (ferr_n - fb != 1) $display("FAIL badstop_ferr_count got %0d want 1", ferr_n - fb); else n_pass++;
        n_total++; if (ferr_c != t0 + LAT) $display("FAIL badstop_ferr_cycle got %0d want %0d", ferr_c, t0 + LAT); else n_pass++;
        n_total++; if (got_d.size() - gb != 0) $display("FAIL badstop_words got %0d want 0", got_d.size() - gb); else n_pass++;
        d = W'({$urandom(), $urandom()});
        send_frame(d, IDLE, 2, t1);
        model_word(d, t1);
        tick(BP);
        n_total++; if (got_d.size() - gb != exp_d.size()) $display("FAIL badstop_next_count got %0d want %0d", got_d.size() - gb, exp_d.size()); else n_pass++;
        for (int i = 0; i < exp_d.size() && gb + i < got_d.size(); i++) begin
            n_total++; if (got_d[gb+i] !== exp_d[i]) $display("FAIL badstop_next_data got %h want %h", got_d[gb+i], exp_d[i]); else n_pass++;
        end
        n_total++; if (ferr_n - fb != 1) $display("FAIL badstop_ferr_total got %0d want 1", ferr_n - fb); else n_pass++;
    endtask

    task automatic test_overrun();
        int t0, t1, gb, ob;
        gb = got_d.size(); ob = ovr_n;
        ready = 1'b0;
        send_frame(48'h111111111111, IDLE, 1, t0);
        send_frame(48'h222222222222, IDLE, 1, t1);
        n_total++; if (valid !== 1'b1) $display("FAIL overrun_valid_held got %b want 1", valid); else n_pass++;
        n_total++; if (data !== 48'h111111111111) $display("FAIL overrun_data_held got %h want 111111111111", data); else n_pass++;
        n_total++; if (ovr_n - ob != 1) $display("FAIL overrun_count got %0d want 1", ovr_n - ob); else n_pass++;
        n_total++; if (ovr_c != t1 + LAT) $display("FAIL overrun_cycle got %0d want %0d", ovr_c, t1 + LAT); else n_pass++;
        ready = 1'b1;
        tick(1);
        n_total++; if (valid !== 1'b0) $display("FAIL overrun_valid_drop got %b want 0", valid); else n_pass++;
        n_total++;
        if (got_d.size() - gb != 1 || got_d[gb] !== 48'h111111111111)
            $display("FAIL overrun_accepted got %0d words want 1 word 111111111111", got_d.size() - gb);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t0, t1, gb, fb, ob;
        logic [W-1:0] y;
        ready = 1'b0;
        send_frame(48'h0F0F0F0F0F0F, IDLE, 1, t0);
        n_total++; if (valid !== 1'b1) $display("FAIL resetmid_pre_valid got %b want 1", valid); else n_pass++;
        y = W'({$urandom(), $urandom()});
        rx = ACT;
        tick(BP);
        for (int k = 0; k < 20; k++) begin
            rx = y[k];
            tick(BP);
        end
        rx = y[20];
        tick(BP / 2);
        gb = got_d.size(); fb = ferr_n; ob = ovr_n;
        reset = 1'b1;
        rx = IDLE;
        tick(1);
        n_total++; if (valid !== 1'b0) $display("FAIL resetmid_valid got %b want 0", valid); else n_pass++;
        n_total++; if (data !== '0) $display("FAIL resetmid_data got %h want 0", data); else n_pass++;
        n_total++; if (frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL resetmid_pulses got %b%b want 00", frame_err, overrun); else n_pass++;
        reset = 1'b0;
        ready = 1'b1;
        tick(LAT + 2 * BP);
        n_total++; if (got_d.size() - gb != 0) $display("FAIL resetmid_words got %0d want 0", got_d.size() - gb); else n_pass++;
        n_total++; if (ferr_n - fb != 0 || ovr_n - ob != 0) $display("FAIL resetmid_errs got %0d/%0d want 0/0", ferr_n - fb, ovr_n - ob); else n_pass++;
        exp_d.delete(); exp_c.delete();
        send_frame(48'h000000000001, IDLE, 2, t1);
        model_word(48'h000000000001, t1);
        tick(BP);
        n_total++; if (got_d.size() - gb != exp_d.size()) $display("FAIL resetmid_next_count got %0d want %0d", got_d.size() - gb, exp_d.size()); else n_pass++;
        for (int i = 0; i < exp_d.size() && gb + i < got_d.size(); i++) begin
            n_total++; if (got_d[gb+i] !== exp_d[i]) $display("FAIL resetmid_next_data got %h want %h", got_d[gb+i], exp_d[i]); else n_pass++;
            n_total++; if (got_c[gb+i] != exp_c[i]) $display("FAIL resetmid_next_latency got %0d want %0d", got_c[gb+i], exp_c[i]); else n_pass++;
        end
    endtask

    task automatic test_random();
        int t0, gb, fb, ob, gap, ferr_exp;
        logic [W-1:0] d;
        logic ok;
        gb = got_d.size(); fb = ferr_n; ob = ovr_n;
        exp_d.delete(); exp_c.delete();
        ferr_exp = 0;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = W'({$urandom(), $urandom()});
            ok = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(1, 3);
            send_frame(d, ok ? IDLE : ACT, gap, t0);
            if (ok) model_word(d, t0);
            else ferr_exp++;
        end
        tick(BP);
        n_total++; if (got_d.size() - gb != exp_d.size()) $display("FAIL random_count got %0d want %0d", got_d.size() - gb, exp_d.size()); else n_pass++;
        for (int i = 0; i < exp_d.size() && gb + i < got_d.size(); i++) begin
            n_total++; if (got_d[gb+i] !== exp_d[i]) $display("FAIL random_data[%0d] got %h want %h", i, got_d[gb+i], exp_d[i]); else n_pass++;
            n_total++; if (got_c[gb+i] != exp_c[i]) $display("FAIL random_latency[%0d] got %0d want %0d", i, got_c[gb+i], exp_c[i]); else n_pass++;
        end
        n_total++; if (ferr_n - fb != ferr_exp) $display("FAIL random_ferr got %0d want %0d", ferr_n - fb, ferr_exp); else n_pass++;
        n_total++; if (ovr_n - ob != 0) $display("FAIL random_overrun got %0d want 0", ovr_n - ob); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_glitch();
        test_bad_stop();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
